// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU external-bus controller.
// State encoding, target select bits and the address map live here.
package mcu_bus_pkg;

  localparam int ADDR_W = 19;
  localparam int SEL_W  = 5;

  localparam int SEL_RAM   = 0;
  localparam int SEL_FREWL = 1;
  localparam int SEL_FREWH = 2;
  localparam int SEL_FIFO  = 3;
  localparam int SEL_SPI   = 4;

  localparam logic [3:0] RAM_PAGE = 4'hA;

  localparam logic [ADDR_W-1:0] FREWL_ADDR = 19'h58400;
  localparam logic [ADDR_W-1:0] FREWH_ADDR = 19'h58800;
  localparam logic [ADDR_W-1:0] FIFO_ADDR  = 19'h58001;
  localparam logic [ADDR_W-1:0] SPI_ADDR   = 19'h58002;

  localparam logic [15:0] FILL_DEAD = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_CYCLE,
    ST_WR,
    ST_WAIT_END,
    ST_RD,
    ST_RD_DRIVE,
    ST_ERR_WAIT
  } state_t;

  function automatic logic [SEL_W-1:0] sel_decode(
    input logic [ADDR_W-1:0] a
  );
    logic [SEL_W-1:0] s;
    s = '0;
    unique case (1'b1)
      (a[18:15] == RAM_PAGE): s[SEL_RAM]   = 1'b1;
      (a == FREWL_ADDR):      s[SEL_FREWL] = 1'b1;
      (a == FREWH_ADDR):      s[SEL_FREWH] = 1'b1;
      (a == FIFO_ADDR):       s[SEL_FIFO]  = 1'b1;
      (a == SPI_ADDR):        s[SEL_SPI]   = 1'b1;
      default:                s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mcu_bus_ctrl_if.sv
// Pin-side and target-side signals of the MCU bus controller.
// slave = the controller, master = MCU pins plus target models.
interface mcu_bus_ctrl_if #(
  parameter int DATA_W = 16
);
  import mcu_bus_pkg::*;

  logic              NADV;
  logic              NWE;
  logic              NOE;
  logic [DATA_W-1:0] AD_IN;
  logic [2:0]        A_HI;
  logic [DATA_W-1:0] AD_OUT;
  logic              AD_OE;
  logic [ADDR_W-1:0] ADDR;
  logic [SEL_W-1:0]  SEL;
  logic [DATA_W-1:0] WDATA;
  logic              WR_STB;
  logic              RD_REQ;
  logic              RD_ACK;
  logic [DATA_W-1:0] RDATA;
  logic              BUSY;
  logic              BUS_ERR;

  modport slave (
    input  NADV, NWE, NOE, AD_IN, A_HI,
    input  RD_ACK, RDATA,
    output AD_OUT, AD_OE, ADDR, SEL, WDATA,
    output WR_STB, RD_REQ, BUSY, BUS_ERR
  );

  modport master (
    output NADV, NWE, NOE, AD_IN, A_HI,
    output RD_ACK, RDATA,
    input  AD_OUT, AD_OE, ADDR, SEL, WDATA,
    input  WR_STB, RD_REQ, BUSY, BUS_ERR
  );

endinterface

// File: rtl/mcu_bus_sync.sv
// Flop-chain synchronizer for one MCU strobe with edge pulses.
// Strobes idle high, so the chain resets to 1 to avoid false edges.
module mcu_bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/mcu_bus_ctrl.sv
// MCU external-bus cycle controller: address latch, decode, wr/rd sequencing.
// Define MCU_BUS_TIMEOUT_EN to bound the read-ack wait by RD_TIMEOUT cycles.
module mcu_bus_ctrl
  import mcu_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 15,
  parameter int DATA_W      = 16
) (
  input logic           CLK,
  input logic           RST_N,
  mcu_bus_ctrl_if.slave bus
);

  logic nadv_q, nadv_rise, nadv_fall;
  logic nwe_q, nwe_rise, nwe_fall;
  logic noe_q, noe_rise, noe_fall;

  mcu_bus_sync #(.STAGES(SYNC_STAGES)) u_nadv (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (bus.NADV),
    .q    (nadv_q),
    .rise (nadv_rise),
    .fall (nadv_fall)
  );

  mcu_bus_sync #(.STAGES(SYNC_STAGES)) u_nwe (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (bus.NWE),
    .q    (nwe_q),
    .rise (nwe_rise),
    .fall (nwe_fall)
  );

  mcu_bus_sync #(.STAGES(SYNC_STAGES)) u_noe (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (bus.NOE),
    .q    (noe_q),
    .rise (noe_rise),
    .fall (noe_fall)
  );

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic              wr_stb;
  logic              rd_req;
  logic              bus_err;

  // End-of-strobe exits use the synced level so a short phase never hangs.
  logic unused_edges;
  assign unused_edges = &{1'b0, nadv_q, nadv_fall, nwe_rise};

`ifdef MCU_BUS_TIMEOUT_EN
  localparam logic [3:0] TMO_LAST = 4'(RD_TIMEOUT - 1);
  logic [3:0] tmo_cnt;
`else
  logic [3:0] unused_tmo;
  assign unused_tmo = 4'(RD_TIMEOUT);
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      addr    <= '0;
      sel     <= '0;
      wdata   <= '0;
      ad_out  <= '0;
      ad_oe   <= 1'b0;
      wr_stb  <= 1'b0;
      rd_req  <= 1'b0;
      bus_err <= 1'b0;
`ifdef MCU_BUS_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      wr_stb <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (nadv_rise) begin
            addr  <= {bus.A_HI, bus.AD_IN};
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          sel   <= sel_decode(addr);
          state <= ST_CYCLE;
        end
        ST_CYCLE: begin
          if (nwe_fall && noe_fall) begin
            bus_err <= 1'b1;
            state   <= ST_ERR_WAIT;
          end else if (nwe_fall) begin
            state <= ST_WR;
          end else if (noe_fall) begin
            rd_req <= |sel;
`ifdef MCU_BUS_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state  <= ST_RD;
          end else if (nadv_rise) begin
            addr  <= {bus.A_HI, bus.AD_IN};
            state <= ST_DECODE;
          end
        end
        ST_WR: begin
          wdata  <= bus.AD_IN;
          wr_stb <= |sel;
          state  <= ST_WAIT_END;
        end
        ST_WAIT_END: begin
          if (nwe_q) state <= ST_IDLE;
        end
        ST_RD: begin
          if (sel == '0) begin
            ad_out <= '0;
            ad_oe  <= 1'b1;
            state  <= ST_RD_DRIVE;
          end else if (noe_rise) begin
            rd_req  <= 1'b0;
            bus_err <= 1'b1;
            state   <= ST_IDLE;
          end else if (bus.RD_ACK) begin
            rd_req <= 1'b0;
            ad_out <= bus.RDATA;
            ad_oe  <= 1'b1;
            state  <= ST_RD_DRIVE;
          end
`ifdef MCU_BUS_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rd_req  <= 1'b0;
            ad_out  <= FILL_DEAD;
            ad_oe   <= 1'b1;
            bus_err <= 1'b1;
            state   <= ST_RD_DRIVE;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
`endif
        end
        ST_RD_DRIVE: begin
          if (noe_q) begin
            ad_oe <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_ERR_WAIT: begin
          if (nwe_q && noe_q) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ADDR    = addr;
  assign bus.SEL     = sel;
  assign bus.WDATA   = wdata;
  assign bus.WR_STB  = wr_stb;
  assign bus.RD_REQ  = rd_req;
  assign bus.AD_OUT  = ad_out;
  assign bus.AD_OE   = ad_oe;
  assign bus.BUS_ERR = bus_err;
  assign bus.BUSY    = (state != ST_IDLE);

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Scoreboard bench for mcu_bus_ctrl: directed MCU cycles, queued expectations.
// Build with MCU_BUS_TIMEOUT_EN to include the read-timeout case.
module tb_mcu_bus_ctrl;
  import mcu_bus_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mcu_bus_ctrl_if #(.DATA_W(16)) bus();

  mcu_bus_ctrl #(
    .SYNC_STAGES(2),
    .RD_TIMEOUT (15),
    .DATA_W     (16)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct {
    string      name;
    logic [4:0] sel;
    logic [15:0] data;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];

  int n_run = 0;
  int n_fail = 0;

  int stb_cnt = 0;
  int req_cnt = 0;
  int oe_cnt = 0;
  logic prev_stb = 1'b0;
  logic prev_oe = 1'b0;

  bit tgt_en = 1'b0;
  int tgt_delay = 1;
  logic [15:0] tgt_data = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    exp_t e;
    if (bus.WR_STB) begin
      if (wr_q.size() == 0) begin
        check("unexpected_wr_stb", 1, 0);
      end else begin
        e = wr_q.pop_front();
        check({e.name, "_sel"}, bus.SEL, e.sel);
        check({e.name, "_wdata"}, bus.WDATA, e.data);
        check({e.name, "_stb_len"}, prev_stb, 0);
      end
    end
    if (bus.AD_OE && !prev_oe) begin
      if (rd_q.size() == 0) begin
        check("unexpected_ad_oe", 1, 0);
      end else begin
        e = rd_q.pop_front();
        check({e.name, "_rsel"}, bus.SEL, e.sel);
        check({e.name, "_ad_out"}, bus.AD_OUT, e.data);
      end
    end
    prev_stb <= bus.WR_STB;
    prev_oe  <= bus.AD_OE;
    if (bus.WR_STB) stb_cnt <= stb_cnt + 1;
    if (bus.RD_REQ) req_cnt <= req_cnt + 1;
    if (bus.AD_OE && !prev_oe) oe_cnt <= oe_cnt + 1;
  end

  // target responder
  initial begin
    int w;
    w = 0;
    bus.RD_ACK = 1'b0;
    bus.RDATA  = '0;
    forever begin
      @(negedge CLK);
      bus.RD_ACK = 1'b0;
      if (bus.RD_REQ && tgt_en) begin
        w++;
        if (w == tgt_delay) begin
          bus.RD_ACK = 1'b1;
          bus.RDATA  = tgt_data;
          w = 0;
        end
      end else begin
        w = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.BUSY && k < 20) begin
      cyc(1);
      k++;
    end
    check({name, "_idle"}, bus.BUSY, 0);
  endtask

  task automatic addr_phase(input logic [18:0] a);
    @(negedge CLK);
    bus.A_HI  = a[18:16];
    bus.AD_IN = a[15:0];
    bus.NADV  = 1'b0;
    cyc(2);
    bus.NADV = 1'b1;
    cyc(6);
  endtask

  task automatic write_phase(input string name, input logic [15:0] d,
                             input logic [4:0] sel);
    int s0;
    if (sel != 0) wr_q.push_back('{name, sel, d});
    s0 = stb_cnt;
    bus.AD_IN = d;
    bus.NWE   = 1'b0;
    cyc(8);
    check({name, "_dec"}, bus.SEL, sel);
    check({name, "_busy"}, bus.BUSY, 1);
    bus.NWE = 1'b1;
    wait_idle(name);
    check({name, "_nstb"}, stb_cnt - s0, (sel != 0) ? 1 : 0);
  endtask

  task automatic do_write(input string name, input logic [18:0] a,
                          input logic [15:0] d, input logic [4:0] sel);
    addr_phase(a);
    write_phase(name, d, sel);
  endtask

  task automatic do_read(input string name, input logic [18:0] a,
                         input logic [4:0] sel, input logic [15:0] d,
                         input int dly, input bit on, output int reqs);
    int r0, k;
    tgt_en = on;
    tgt_delay = dly;
    tgt_data = d;
    rd_q.push_back('{name, sel, d});
    r0 = req_cnt;
    addr_phase(a);
    bus.NOE = 1'b0;
    k = 0;
    while (!bus.AD_OE && k < 40) begin
      cyc(1);
      k++;
    end
    check({name, "_oe_on"}, bus.AD_OE, 1);
    cyc(3);
    check({name, "_hold"}, {bus.AD_OE, bus.AD_OUT}, {1'b1, d});
    bus.NOE = 1'b1;
    k = 0;
    while (bus.AD_OE && k < 10) begin
      cyc(1);
      k++;
    end
    check({name, "_oe_off"}, bus.AD_OE, 0);
    wait_idle(name);
    reqs = req_cnt - r0;
    tgt_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    cyc(2);
    RST_N = 1'b1;
    cyc(2);
  endtask

  initial begin
    int reqs, k, r0, s0, o0;
    bus.NADV  = 1'b1;
    bus.NWE   = 1'b1;
    bus.NOE   = 1'b1;
    bus.AD_IN = '0;
    bus.A_HI  = '0;
    cyc(3);
    check("rst_ad_oe", bus.AD_OE, 0);
    check("rst_sel", bus.SEL, 0);
    check("rst_addr", bus.ADDR, 0);
    check("rst_ad_out", bus.AD_OUT, 0);
    check("rst_flags", {bus.BUSY, bus.BUS_ERR, bus.WR_STB, bus.RD_REQ}, 0);
    RST_N = 1'b1;
    cyc(2);

    do_write("T1_frewl", 19'h58400, 16'h1234, 5'b00010);
    check("T1_addr", bus.ADDR, 19'h58400);

    do_read("T2_ram", 19'h50010, 5'b00001, 16'hBEEF, 3, 1'b1, reqs);
    check("T2_req_cycles", reqs, 3);

    do_read("T3_unmapped", 19'h00000, 5'b00000, 16'h0000, 1, 1'b1, reqs);
    check("T3_no_req", reqs, 0);
    check("T3_no_err", bus.BUS_ERR, 0);

    do_write("Tw_ram_edge", 19'h57FFF, 16'h0F0F, 5'b00001);
    do_write("Tw_unmapped", 19'h58000, 16'h7777, 5'b00000);
    do_write("Tw_spi", 19'h58002, 16'hA5A5, 5'b10000);
    addr_phase(19'h58002);
    addr_phase(19'h58001);
    write_phase("Tw_relatch", 16'h4321, 5'b01000);

    // NOE released while the request is still pending
    tgt_en = 1'b0;
    o0 = oe_cnt;
    addr_phase(19'h58002);
    bus.NOE = 1'b0;
    k = 0;
    while (!bus.RD_REQ && k < 20) begin
      cyc(1);
      k++;
    end
    check("T4_req_lat", k, 3);
    cyc(2);
    bus.NOE = 1'b1;
    k = 0;
    while (bus.RD_REQ && k < 10) begin
      cyc(1);
      k++;
    end
    check("T4_req_drop", k, 3);
    cyc(4);
    check("T4_no_oe", oe_cnt - o0, 0);
    check("T4_err", bus.BUS_ERR, 1);
    check("T4_idle", bus.BUSY, 0);

    // reset while driving read data
    tgt_en = 1'b1;
    tgt_delay = 1;
    tgt_data = 16'h5A5A;
    rd_q.push_back('{"T6_rd", 5'b00010, 16'h5A5A});
    addr_phase(19'h58400);
    bus.NOE = 1'b0;
    k = 0;
    while (!bus.AD_OE && k < 40) begin
      cyc(1);
      k++;
    end
    check("T6_oe_on", bus.AD_OE, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("T6_async_oe", bus.AD_OE, 0);
    check("T6_async_sel", bus.SEL, 0);
    check("T6_async_err", bus.BUS_ERR, 0);
    check("T6_async_busy", bus.BUSY, 0);
    tgt_en = 1'b0;
    bus.NOE = 1'b1;
    cyc(3);
    RST_N = 1'b1;
    cyc(2);
    do_write("T6_frewh", 19'h58800, 16'hCAFE, 5'b00100);

`ifdef MCU_BUS_TIMEOUT_EN
    do_read("T5_tmo", 19'h58001, 5'b01000, 16'hDEAD, 1, 1'b0, reqs);
    check("T5_req_cycles", reqs, 15);
    check("T5_err", bus.BUS_ERR, 1);
    do_reset();
`endif

    // both strobes fall together
    s0 = stb_cnt;
    r0 = req_cnt;
    addr_phase(19'h58001);
    bus.NWE = 1'b0;
    bus.NOE = 1'b0;
    cyc(8);
    check("T7_err", bus.BUS_ERR, 1);
    bus.NWE = 1'b1;
    bus.NOE = 1'b1;
    wait_idle("T7");
    check("T7_no_stb", stb_cnt - s0, 0);
    check("T7_no_req", req_cnt - r0, 0);

    cyc(2);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
